lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles in ACCESS awaiting mem_ready before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  begin a load/store; sampled only in IDLE.
REQ-005 is_store  in  1  1 = store, 0 = load.
REQ-006 funct3  in  3  width code: 000 b, 001 h, 010 w, 100 bu, 101 hu; other codes illegal.
REQ-007 addr  in  32  effective byte address.
REQ-008 wdata  in  32  store data (rs2), right-aligned.
REQ-009 mem_req  out  1  memory request, held high until accepted.
REQ-010 mem_we  out  1  write strobe, qualified by mem_req.
REQ-011 mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-012 mem_wdata  out  32  store data shifted to byte lane.
REQ-013 mem_be  out  4  byte enables.
REQ-014 mem_ready  in  1  memory accept/complete.
REQ-015 mem_rdata  in  32  read data, valid when mem_ready=1.
REQ-016 load_data  out  32  read word shifted right by 8*addr[1:0]; feeds mem_inp of sign_extend_module (extension done there).
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 fault  out  1  misaligned/illegal funct3, valid with done.
REQ-020 timeout  out  1  memory timeout, valid with done.

Function
REQ-021 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on start when access legal; IDLE->DONE on start when illegal; ACCESS->DONE on mem_ready or timeout; DONE->IDLE unconditionally.
REQ-022 addr, funct3, is_store, wdata captured on the start cycle; later input changes ignored until IDLE.
REQ-023 Misaligned: h/hu with addr[0]=1, w with addr[1:0]!=0; these and illegal funct3 (incl. any store with funct3 not 000/001/010) -> fault=1, no mem_req asserted.
REQ-024 mem_req=1 throughout ACCESS, mem_addr/mem_we/mem_be/mem_wdata stable while mem_req=1.
REQ-025 mem_be: b = 4'b0001<<addr[1:0]; h = 4'b0011<<addr[1:0]; w = 4'b1111; loads drive the same enables.
REQ-026 mem_wdata = wdata << 8*addr[1:0]; bytes outside mem_be are don't-care.
REQ-027 On ACCESS with mem_ready=1 and load, load_data registered as mem_rdata >> 8*addr[1:0] (zero fill in upper bits); held until next load completes.
REQ-028 Wait counter cleared on entry to ACCESS, increments each ACCESS cycle with mem_ready=0; reaching TIMEOUT_CYCLES -> DONE with timeout=1, load_data unchanged.
REQ-029 mem_ready in same cycle as counter limit: completion wins, timeout=0.
REQ-030 Latency: zero-wait memory -> done 2 cycles after start; illegal access -> done 1 cycle after start.
REQ-031 done, fault, timeout high only in DONE; exactly one cycle each.
REQ-032 start while busy=1 ignored; start in DONE cycle ignored.
REQ-033 mem_ready outside ACCESS ignored.

Reset
REQ-034 rst_n=0 at a clock edge forces IDLE, counter 0, load_data 0, all outputs 0, mem_be 0, including mid-ACCESS (request dropped, no done).

Structure
REQ-035 Shared package: funct3 width codes, FSM state enum, TIMEOUT counter width function.
REQ-036 One sub-module natural: lsu_lane_align (combinational byte-enable/shift/misalign generation).

Verification
REQ-037 lb addr 0x1003, mem_rdata 0xAABBCCDD, ready 1 cycle later -> mem_addr 0x1000, mem_be 0001<<3=1000, load_data 0x000000AA, done 2 cycles after start.
REQ-038 sh addr 0x2002, wdata 0x00001234 -> mem_we 1, mem_be 1100, mem_wdata[31:16]=0x1234, done fault=0.
REQ-039 lw addr 0x3001 -> no mem_req, done+fault 1 cycle after start.
REQ-040 lw, mem_ready never asserted, TIMEOUT_CYCLES=4 -> done+timeout after 4 ACCESS cycles, load_data unchanged.
REQ-041 rst_n low during ACCESS -> next cycle IDLE, mem_req 0, no done pulse; following lw completes normally.
REQ-042 start pulsed during ACCESS and DONE -> ignored, single transaction observed.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared funct3 codes, FSM state type and counter sizing for the LSU controller
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  // Bits needed to hold values 0..limit; never less than one.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(limit)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - memory-side request/response bus between the LSU and the data memory
interface lsu_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl_lane_align.sv
// rtl/lsu_ctrl_lane_align.sv - byte-enable, lane shift and legality decode for one access
module lsu_lane_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_sh,
  output logic        illegal
);

  always_comb begin
    be      = 4'b0000;
    illegal = 1'b0;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << offset;
      F3_H, F3_HU: begin
        be      = 4'b0011 << offset;
        illegal = offset[0];
      end
      F3_W: begin
        be      = 4'b1111;
        illegal = |offset;
      end
      default: illegal = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (is_store && funct3[2]) illegal = 1'b1;
  end

  assign wdata_sh = wdata << {offset, 3'b000};
  assign rdata_sh = rdata >> {offset, 3'b000};

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller: one memory access per start, with misalign fault and wait timeout
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_store,
  input  logic [2:0]   funct3,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  lsu_ctrl_if.master   mem,
  output logic [31:0]  load_data,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output logic         timeout
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state, state_n;
  logic [31:0] addr_q, wdata_q, load_data_q;
  logic [2:0]  funct3_q;
  logic        is_store_q, fault_q, timeout_q;
  logic [CW-1:0] cnt;

  logic        idle, access;
  logic [1:0]  al_offset;
  logic [2:0]  al_funct3;
  logic        al_store;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] al_wdata_sh, al_rdata_sh;
  logic        al_illegal;
  logic        wait_expired;

  assign idle   = (state == ST_IDLE);
  assign access = (state == ST_ACCESS);

  // In IDLE the decoder looks at live inputs to judge legality; afterwards it sees the captured access.
  assign al_offset = idle ? addr[1:0] : addr_q[1:0];
  assign al_funct3 = idle ? funct3    : funct3_q;
  assign al_store  = idle ? is_store  : is_store_q;
  assign al_wdata  = idle ? wdata     : wdata_q;

  lsu_lane_align u_align (
    .offset   (al_offset),
    .funct3   (al_funct3),
    .is_store (al_store),
    .wdata    (al_wdata),
    .rdata    (mem.mem_rdata),
    .be       (al_be),
    .wdata_sh (al_wdata_sh),
    .rdata_sh (al_rdata_sh),
    .illegal  (al_illegal)
  );

  assign wait_expired = !mem.mem_ready && (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start) state_n = al_illegal ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (mem.mem_ready || wait_expired) state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      is_store_q  <= 1'b0;
      fault_q     <= 1'b0;
      timeout_q   <= 1'b0;
      cnt         <= '0;
      load_data_q <= '0;
    end else begin
      state <= state_n;
      if (idle && start) begin
        addr_q     <= addr;
        wdata_q    <= wdata;
        funct3_q   <= funct3;
        is_store_q <= is_store;
        fault_q    <= al_illegal;
        timeout_q  <= 1'b0;
        cnt        <= '0;
      end
      if (access) begin
        // A response arriving on the last permitted cycle still completes the access.
        if (mem.mem_ready) begin
          if (!is_store_q) load_data_q <= al_rdata_sh;
        end else if (wait_expired) begin
          timeout_q <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign mem.mem_req   = access;
  assign mem.mem_we    = access & is_store_q;
  assign mem.mem_addr  = access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem.mem_be    = access ? al_be : 4'b0000;
  assign mem.mem_wdata = access ? al_wdata_sh : 32'h0;

  assign load_data = load_data_q;
  assign busy      = !idle;
  assign done      = (state == ST_DONE);
  assign fault     = done & fault_q;
  assign timeout   = done & timeout_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a behavioural access model
module tb_lsu_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, load_data;
  logic        busy, done, fault, timeout;

  lsu_ctrl_if mif ();

  lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .mem       (mif),
    .load_data (load_data),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        fault;
    logic        timeout;
    logic [31:0] load_data;
    int          cyc;
  } res_exp_t;

  mem_exp_t mem_q[$];
  res_exp_t res_q[$];
  mem_exp_t cur_mem;
  bit       cur_valid = 0;
  bit       prev_req = 0;
  int       cyc = 0;
  int       checks = 0;
  int       errors = 0;
  logic [31:0] last_load = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Access size in bytes from the ISA rules; 0 marks an illegal code.
  function automatic int acc_size(input bit st, input logic [2:0] f3);
    int s;
    case (f3)
      3'b000, 3'b100: s = 1;
      3'b001, 3'b101: s = 2;
      3'b010:         s = 4;
      default:        s = 0;
    endcase
    if (st && f3 > 3'b010) s = 0;
    return s;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (mif.mem_req && !prev_req) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_req: got mem_req=1 expected no request");
          cur_valid = 0;
        end else begin
          cur_mem = mem_q.pop_front();
          cur_valid = 1;
        end
      end
      if (mif.mem_req && cur_valid) begin
        chk("mem_addr", mif.mem_addr, cur_mem.addr);
        chk("mem_be", {28'h0, mif.mem_be}, {28'h0, cur_mem.be});
        chk("mem_we", {31'h0, mif.mem_we}, {31'h0, cur_mem.we});
        if (cur_mem.we)
          chk("mem_wdata", mif.mem_wdata & be_mask(cur_mem.be), cur_mem.wdata & be_mask(cur_mem.be));
      end
      if (!mif.mem_req) cur_valid = 0;
      if (done) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          res_exp_t e;
          e = res_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("fault", {31'h0, fault}, {31'h0, e.fault});
          chk("timeout", {31'h0, timeout}, {31'h0, e.timeout});
          chk("load_data", load_data, e.load_data);
          chk("busy_in_done", {31'h0, busy}, 32'h1);
        end
      end else begin
        chk("fault_outside_done", {31'h0, fault}, 32'h0);
        chk("timeout_outside_done", {31'h0, timeout}, 32'h0);
      end
    end
    prev_req = mif.mem_req;
  end

  task automatic scramble();
    is_store = 1'($urandom);
    funct3   = 3'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  // lat: ACCESS cycle index at which mem_ready rises; -1 means never.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic [31:0] rd,
                         input bit noise);
    int sz, off, i;
    bit legal;
    mem_exp_t m;
    res_exp_t r;
    sz    = acc_size(st, f3);
    off   = int'(a % 4);
    legal = (sz != 0) && (a % sz == 0);
    r.fault = 0; r.timeout = 0;
    if (legal) begin
      m.addr  = a - (a % 4);
      m.be    = 4'(((1 << sz) - 1) << off);
      m.we    = st;
      m.wdata = wd << (8 * off);
      mem_q.push_back(m);
      if (lat >= 0 && lat < T) begin
        r.cyc = cyc + 2 + lat;
        if (!st) last_load = rd >> (8 * off);
      end else begin
        r.timeout = 1;
        r.cyc = cyc + 1 + T;
      end
    end else begin
      r.fault = 1;
      r.cyc = cyc + 1;
    end
    r.load_data = last_load;
    res_q.push_back(r);

    start = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    mif.mem_ready = 1'($urandom); mif.mem_rdata = $urandom;
    @(posedge clk); #1;
    start = noise ? 1'($urandom) : 1'b0;
    scramble();
    i = 0;
    while (!done && i < 40) begin
      mif.mem_ready = (i == lat);
      mif.mem_rdata = (i == lat) ? rd : $urandom;
      @(posedge clk); #1;
      i++;
      start = noise ? 1'($urandom) : 1'b0;
      scramble();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_wait: got no done within 40 cycles expected a completion");
    end
    start = noise; mif.mem_ready = 1'($urandom);
    @(posedge clk); #1;
    start = 0; mif.mem_ready = 0;
    repeat ($urandom_range(0, 2)) begin
      mif.mem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    mif.mem_ready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    mif.mem_ready = 0; mif.mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_mem_req", {31'h0, mif.mem_req}, 32'h0);
    chk("rst_mem_be", {28'h0, mif.mem_be}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    rst_n = 1;
    @(posedge clk); #1;

    run_txn(0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'hAABBCCDD, 0);
    chk("lb_load_data", load_data, 32'h0000_00AA);
    run_txn(1, 3'b001, 32'h0000_2002, 32'h0000_1234, 0, 32'h0, 0);
    run_txn(0, 3'b010, 32'h0000_3001, 32'h0, 0, 32'h0, 0);
    run_txn(0, 3'b010, 32'h0000_3000, 32'h0, -1, 32'h0, 0);
    chk("timeout_keeps_load", load_data, 32'h0000_00AA);
    run_txn(0, 3'b101, 32'h0000_0042, 32'h0, T - 1, 32'h8765_4321, 0);
    run_txn(1, 3'b100, 32'h0000_0010, 32'h5, 0, 32'h0, 0);
    run_txn(0, 3'b011, 32'h0000_0010, 32'h0, 0, 32'h0, 0);
    run_txn(1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 2, 32'h0, 1);

    // Reset in the middle of a load: request dropped, no completion.
    m_reset_mid_access();
    run_txn(0, 3'b010, 32'h0000_4004, 32'h0, 1, 32'h1234_5678, 1);
    chk("after_reset_lw", load_data, 32'h1234_5678);

    for (int n = 0; n < 200; n++) begin
      logic [2:0] f3;
      int r, lat;
      r   = $urandom_range(0, 6);
      lat = (r > 4) ? -1 : r;
      case ($urandom_range(0, 5))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        4: f3 = 3'b101;
        default: f3 = 3'($urandom);
      endcase
      run_txn(1'($urandom), f3, $urandom, $urandom, lat, $urandom, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("mem_queue_empty", mem_q.size(), 0);
    chk("res_queue_empty", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic m_reset_mid_access();
    mem_exp_t m;
    m.addr = 32'h0000_5000; m.be = 4'b1111; m.we = 0; m.wdata = 32'h0;
    mem_q.push_back(m);
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h0000_5000; wdata = 0;
    mif.mem_ready = 0;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    chk("pre_reset_mem_req", {31'h0, mif.mem_req}, 32'h1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_reset_busy", {31'h0, busy}, 32'h0);
    chk("mid_reset_mem_req", {31'h0, mif.mem_req}, 32'h0);
    chk("mid_reset_done", {31'h0, done}, 32'h0);
    chk("mid_reset_load_data", load_data, 32'h0);
    last_load = 32'h0;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

endmodule
